// File: rtl/chip_valve_sequencer_if.sv
// Command/status/valve bundle between a controller and the ChIP valve sequencer.
// master = command issuer, slave = sequencer.
interface chip_valve_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_inlet;
   logic [7:0] cmd_strokes;
   logic       abort;
   logic       busy;
   logic       done;
   logic       aborted;
   logic       err_inlet;
   logic [7:0] stroke_cnt;
   logic [4:0] ctrl_inlet;
   logic [2:0] pump;
   logic [4:0] flush_inlet;
   logic [2:0] flush_pump;

   modport master (
      output cmd_valid, cmd_inlet, cmd_strokes, abort,
      input  cmd_ready, busy, done, aborted, err_inlet, stroke_cnt,
      input  ctrl_inlet, pump, flush_inlet, flush_pump
   );

   modport slave (
      input  cmd_valid, cmd_inlet, cmd_strokes, abort,
      output cmd_ready, busy, done, aborted, err_inlet, stroke_cnt,
      output ctrl_inlet, pump, flush_inlet, flush_pump
   );
endinterface

// File: rtl/chip_valve_sequencer.sv
// Valve sequencer for the ChIP chip: open inlet, run N peristaltic strokes, close, optional flush.
// Optional flush phase is compiled in with `define CHIP_SEQ_FLUSH_EN.
module chip_valve_sequencer #(
   parameter int PHASE_CYCLES  = 1000,
   parameter int SETTLE_CYCLES = 50,
   parameter int FLUSH_CYCLES  = 200
) (
   input  logic                        clk,
   input  logic                        rst_n,
   chip_valve_sequencer_if.slave       bus
);

   localparam int MAX_A  = (PHASE_CYCLES > SETTLE_CYCLES) ? PHASE_CYCLES : SETTLE_CYCLES;
   localparam int MAX_P  = (MAX_A > FLUSH_CYCLES) ? MAX_A : FLUSH_CYCLES;
   localparam int TW     = $clog2(MAX_P) + 1;
   localparam logic [TW-1:0] PHASE_LOAD  = TW'(PHASE_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_PUMP, S_CLOSE, S_FLUSH, S_DONE
   } state_t;

   state_t        state_reg;
   logic [TW-1:0] timer_reg;
   logic [2:0]    phase_reg;
   logic [2:0]    inlet_reg;
   logic [7:0]    strokes_reg;
   logic [7:0]    stroke_cnt_reg;
   logic [4:0]    ctrl_inlet_reg;
   logic [2:0]    pump_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          aborted_reg;
   logic          err_inlet_reg;
   logic [7:0]    stroke_cnt_next;

   assign stroke_cnt_next = stroke_cnt_reg + 8'd1;

   // Six-step peristaltic pattern; 0 = valve open.
   function automatic logic [2:0] pump_pattern(input logic [2:0] ph);
      case (ph)
         3'd0:    pump_pattern = 3'b101;
         3'd1:    pump_pattern = 3'b100;
         3'd2:    pump_pattern = 3'b110;
         3'd3:    pump_pattern = 3'b010;
         3'd4:    pump_pattern = 3'b011;
         3'd5:    pump_pattern = 3'b001;
         default: pump_pattern = 3'b111;
      endcase
   endfunction

`ifdef CHIP_SEQ_FLUSH_EN
   localparam logic [TW-1:0] FLUSH_LOAD = TW'(FLUSH_CYCLES - 1);
   logic [4:0] flush_inlet_reg;
   logic [2:0] flush_pump_reg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         timer_reg      <= '0;
         phase_reg      <= '0;
         inlet_reg      <= '0;
         strokes_reg    <= '0;
         stroke_cnt_reg <= '0;
         ctrl_inlet_reg <= 5'b11111;
         pump_reg       <= 3'b111;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         aborted_reg    <= 1'b0;
         err_inlet_reg  <= 1'b0;
`ifdef CHIP_SEQ_FLUSH_EN
         flush_inlet_reg <= '0;
         flush_pump_reg  <= '0;
`endif
      end else begin
         done_reg      <= 1'b0;
         err_inlet_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (bus.cmd_valid && !busy_reg) begin
                  if (bus.cmd_inlet > 3'd4) begin
                     err_inlet_reg <= 1'b1;
                  end else if (bus.cmd_strokes == 8'd0) begin
                     stroke_cnt_reg <= '0;
                     aborted_reg    <= 1'b0;
                     busy_reg       <= 1'b1;
                     done_reg       <= 1'b1;
                     state_reg      <= S_DONE;
                  end else begin
                     inlet_reg      <= bus.cmd_inlet;
                     strokes_reg    <= bus.cmd_strokes;
                     stroke_cnt_reg <= '0;
                     aborted_reg    <= 1'b0;
                     busy_reg       <= 1'b1;
                     ctrl_inlet_reg <= ~(5'd1 << bus.cmd_inlet);
                     timer_reg      <= SETTLE_LOAD;
                     state_reg      <= S_SETTLE;
                  end
               end
            end
            S_SETTLE, S_PUMP: begin
               if (bus.abort) begin
                  // Partial stroke is dropped; stroke_cnt keeps only completed strokes.
                  aborted_reg    <= 1'b1;
                  ctrl_inlet_reg <= 5'b11111;
                  pump_reg       <= 3'b111;
                  timer_reg      <= SETTLE_LOAD;
                  state_reg      <= S_CLOSE;
               end else if (timer_reg != '0) begin
                  timer_reg <= timer_reg - TW'(1);
               end else if (state_reg == S_SETTLE) begin
                  phase_reg      <= 3'd0;
                  pump_reg       <= pump_pattern(3'd0);
                  ctrl_inlet_reg <= ~(5'd1 << inlet_reg);
                  timer_reg      <= PHASE_LOAD;
                  state_reg      <= S_PUMP;
               end else if (phase_reg == 3'd5) begin
                  stroke_cnt_reg <= stroke_cnt_next;
                  if (stroke_cnt_next == strokes_reg) begin
                     ctrl_inlet_reg <= 5'b11111;
                     pump_reg       <= 3'b111;
                     timer_reg      <= SETTLE_LOAD;
                     state_reg      <= S_CLOSE;
                  end else begin
                     phase_reg <= 3'd0;
                     pump_reg  <= pump_pattern(3'd0);
                     timer_reg <= PHASE_LOAD;
                  end
               end else begin
                  phase_reg <= phase_reg + 3'd1;
                  pump_reg  <= pump_pattern(phase_reg + 3'd1);
                  timer_reg <= PHASE_LOAD;
               end
            end
            S_CLOSE: begin
               if (timer_reg != '0) begin
                  timer_reg <= timer_reg - TW'(1);
               end else begin
`ifdef CHIP_SEQ_FLUSH_EN
                  flush_inlet_reg <= 5'd1 << inlet_reg;
                  flush_pump_reg  <= 3'b111;
                  timer_reg       <= FLUSH_LOAD;
                  state_reg       <= S_FLUSH;
`else
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
`endif
               end
            end
`ifdef CHIP_SEQ_FLUSH_EN
            S_FLUSH: begin
               if (timer_reg != '0) begin
                  timer_reg <= timer_reg - TW'(1);
               end else begin
                  flush_inlet_reg <= '0;
                  flush_pump_reg  <= '0;
                  done_reg        <= 1'b1;
                  state_reg       <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = !busy_reg;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.aborted    = aborted_reg;
   assign bus.err_inlet  = err_inlet_reg;
   assign bus.stroke_cnt = stroke_cnt_reg;
   assign bus.ctrl_inlet = ctrl_inlet_reg;
   assign bus.pump       = pump_reg;
`ifdef CHIP_SEQ_FLUSH_EN
   assign bus.flush_inlet = flush_inlet_reg;
   assign bus.flush_pump  = flush_pump_reg;
`else
   assign bus.flush_inlet = '0;
   assign bus.flush_pump  = '0;
`endif

endmodule

// File: tb/tb_chip_valve_sequencer.sv
// Directed bench for chip_valve_sequencer (PHASE=4, SETTLE=2, FLUSH=3); honours CHIP_SEQ_FLUSH_EN.
`timescale 1ns/1ps
module tb_chip_valve_sequencer;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

`ifdef CHIP_SEQ_FLUSH_EN
   localparam int FL = 3;
`else
   localparam int FL = 0;
`endif

   logic [2:0] pat [6];

   chip_valve_sequencer_if bus();

   chip_valve_sequencer #(
      .PHASE_CYCLES  (4),
      .SETTLE_CYCLES (2),
      .FLUSH_CYCLES  (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench sampling period 1 (just after the handshake edge).
   task automatic issue(input logic [2:0] inl, input logic [7:0] st);
      int w;
      w = 0;
      while (bus.cmd_ready !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL issue_ready actual=%b required=1", bus.cmd_ready);
      end
      bus.cmd_inlet   = inl;
      bus.cmd_strokes = st;
      bus.cmd_valid   = 1'b1;
      tick();
      bus.cmd_valid   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_inlet = '0; bus.cmd_strokes = '0; bus.abort = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus.ctrl_inlet, bus.pump, bus.flush_inlet, bus.flush_pump, bus.busy, bus.done,
           bus.aborted, bus.err_inlet, bus.stroke_cnt} !== {5'b11111, 3'b111, 5'b0, 3'b0, 4'b0, 8'd0}) begin
         failures++;
         $display("FAIL reset_values ctrl=%b pump=%b fi=%b fp=%b busy=%b done=%b cnt=%0d required ctrl=11111 pump=111 rest 0",
                  bus.ctrl_inlet, bus.pump, bus.flush_inlet, bus.flush_pump, bus.busy, bus.done, bus.stroke_cnt);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if ({bus.ctrl_inlet, bus.pump, bus.flush_inlet, bus.flush_pump, bus.cmd_ready, bus.busy, bus.done}
             !== {5'b11111, 3'b111, 5'b0, 3'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL idle_hold cycle=%0d ctrl=%b pump=%b ready=%b busy=%b required ctrl=11111 pump=111 ready=1 busy=0",
                     c, bus.ctrl_inlet, bus.pump, bus.cmd_ready, bus.busy);
         end
      end
   endtask

   task automatic test_single_stroke();
      logic [4:0] e_ctrl, e_fi;
      logic [2:0] e_pump, e_fp;
      logic       e_done, e_busy;
      issue(3'd2, 8'd1);
      for (int p = 1; p <= 40; p++) begin
         e_ctrl = (p <= 26) ? 5'b11011 : 5'b11111;
         e_pump = (p >= 3 && p <= 26) ? pat[(p - 3) / 4] : 3'b111;
         e_fi   = (FL > 0 && p >= 29 && p <= 31) ? 5'b00100 : 5'b00000;
         e_fp   = (FL > 0 && p >= 29 && p <= 31) ? 3'b111 : 3'b000;
         e_done = (p == 29 + FL);
         e_busy = (p <= 29 + FL);
         checks++;
         if ({bus.ctrl_inlet, bus.pump, bus.flush_inlet, bus.flush_pump, bus.done, bus.busy}
             !== {e_ctrl, e_pump, e_fi, e_fp, e_done, e_busy}) begin
            failures++;
            $display("FAIL stroke1_p%0d ctrl=%b pump=%b fi=%b fp=%b done=%b busy=%b required ctrl=%b pump=%b fi=%b fp=%b done=%b busy=%b",
                     p, bus.ctrl_inlet, bus.pump, bus.flush_inlet, bus.flush_pump, bus.done, bus.busy,
                     e_ctrl, e_pump, e_fi, e_fp, e_done, e_busy);
         end
         tick();
      end
      checks++;
      if (bus.stroke_cnt !== 8'd1 || bus.aborted !== 1'b0) begin
         failures++;
         $display("FAIL stroke1_count cnt=%0d aborted=%b required cnt=1 aborted=0", bus.stroke_cnt, bus.aborted);
      end
   endtask

   task automatic test_multi_stroke();
      int done_p;
      done_p = -1;
      issue(3'd0, 8'd3);
      for (int p = 1; p <= 120 && done_p < 0; p++) begin
         if (p == 26 || p == 27 || p == 51) begin
            checks++;
            if (bus.stroke_cnt !== ((p == 26) ? 8'd0 : (p == 27) ? 8'd1 : 8'd2)) begin
               failures++;
               $display("FAIL stroke3_cnt_p%0d actual=%0d required=%0d", p, bus.stroke_cnt,
                        (p == 26) ? 0 : (p == 27) ? 1 : 2);
            end
         end
         if (p == 40) begin
            checks++;
            if (bus.ctrl_inlet !== 5'b11110) begin
               failures++;
               $display("FAIL stroke3_inlet actual=%b required=11110", bus.ctrl_inlet);
            end
         end
         if (bus.done === 1'b1) done_p = p;
         else tick();
      end
      checks++;
      if (done_p != 77 + FL || bus.stroke_cnt !== 8'd3 || bus.aborted !== 1'b0) begin
         failures++;
         $display("FAIL stroke3_done period=%0d cnt=%0d aborted=%b required period=%0d cnt=3 aborted=0",
                  done_p, bus.stroke_cnt, bus.aborted, 77 + FL);
      end
      tick();
   endtask

   task automatic test_abort();
      int p;
      int done_p;
      done_p = -1;
      issue(3'd4, 8'd5);
      repeat (11) tick();
      checks++;
      if (bus.pump !== 3'b110 || bus.ctrl_inlet !== 5'b01111) begin
         failures++;
         $display("FAIL abort_pre pump=%b ctrl=%b required pump=110 ctrl=01111", bus.pump, bus.ctrl_inlet);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      p = 13;
      checks++;
      if (bus.pump !== 3'b111 || bus.ctrl_inlet !== 5'b11111 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_close pump=%b ctrl=%b busy=%b required pump=111 ctrl=11111 busy=1",
                  bus.pump, bus.ctrl_inlet, bus.busy);
      end
      while (done_p < 0 && p < 60) begin
         if (bus.done === 1'b1) done_p = p;
         else begin
            tick();
            p++;
         end
      end
      checks++;
      if (done_p != 15 + FL || bus.aborted !== 1'b1 || bus.stroke_cnt !== 8'd0) begin
         failures++;
         $display("FAIL abort_done period=%0d aborted=%b cnt=%0d required period=%0d aborted=1 cnt=0",
                  done_p, bus.aborted, bus.stroke_cnt, 15 + FL);
      end
      tick();
   endtask

   task automatic test_err_and_zero();
      issue(3'd5, 8'd9);
      checks++;
      if ({bus.err_inlet, bus.busy, bus.done, bus.ctrl_inlet, bus.pump} !== {1'b1, 1'b0, 1'b0, 5'b11111, 3'b111}) begin
         failures++;
         $display("FAIL err_pulse err=%b busy=%b done=%b ctrl=%b pump=%b required err=1 busy=0 done=0 ctrl=11111 pump=111",
                  bus.err_inlet, bus.busy, bus.done, bus.ctrl_inlet, bus.pump);
      end
      tick();
      checks++;
      if (bus.err_inlet !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL err_clear err=%b busy=%b required err=0 busy=0", bus.err_inlet, bus.busy);
      end
      issue(3'd1, 8'd0);
      checks++;
      if ({bus.done, bus.aborted, bus.stroke_cnt, bus.ctrl_inlet, bus.pump} !== {1'b1, 1'b0, 8'd0, 5'b11111, 3'b111}) begin
         failures++;
         $display("FAIL zero_done done=%b aborted=%b cnt=%0d ctrl=%b pump=%b required done=1 aborted=0 cnt=0 ctrl=11111 pump=111",
                  bus.done, bus.aborted, bus.stroke_cnt, bus.ctrl_inlet, bus.pump);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_after done=%b busy=%b required done=0 busy=0", bus.done, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      issue(3'd1, 8'd2);
      repeat (7) tick();
      checks++;
      if (bus.ctrl_inlet !== 5'b11101 || bus.pump !== 3'b100) begin
         failures++;
         $display("FAIL mid_pump ctrl=%b pump=%b required ctrl=11101 pump=100", bus.ctrl_inlet, bus.pump);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.ctrl_inlet, bus.pump, bus.busy, bus.done, bus.stroke_cnt} !== {5'b11111, 3'b111, 1'b0, 1'b0, 8'd0}) begin
         failures++;
         $display("FAIL async_reset ctrl=%b pump=%b busy=%b done=%b cnt=%0d required ctrl=11111 pump=111 busy=0 done=0 cnt=0",
                  bus.ctrl_inlet, bus.pump, bus.busy, bus.done, bus.stroke_cnt);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset done=%b ready=%b required done=0 ready=1", bus.done, bus.cmd_ready);
      end
   endtask

   task automatic test_back_to_back();
      int done_p;
      for (int k = 0; k < 2; k++) begin
         done_p = -1;
         issue((k == 0) ? 3'd3 : 3'd2, (k == 0) ? 8'd1 : 8'd2);
         for (int p = 1; p <= 120 && done_p < 0; p++) begin
            if (bus.done === 1'b1) done_p = p;
            else tick();
         end
         checks++;
         if (done_p != ((k == 0) ? 29 : 53) + FL || bus.stroke_cnt !== ((k == 0) ? 8'd1 : 8'd2)) begin
            failures++;
            $display("FAIL b2b_%0d period=%0d cnt=%0d required period=%0d cnt=%0d",
                     k, done_p, bus.stroke_cnt, ((k == 0) ? 29 : 53) + FL, (k == 0) ? 1 : 2);
         end
      end
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      pat[0] = 3'b101; pat[1] = 3'b100; pat[2] = 3'b110;
      pat[3] = 3'b010; pat[4] = 3'b011; pat[5] = 3'b001;
      test_reset();
      test_single_stroke();
      test_multi_stroke();
      test_abort();
      test_err_and_zero();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
